// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime frame format (data bits, parity, stop bits)
// and a small valid/ready input FIFO so words can be sent back-to-back.
//
// Ports:
//   clk, tx_rst_n       clock, synchronous active-low reset
//   tx_en               freezes FSM, tick counting and FIFO pop when low
//   din/din_valid       push interface, din_ready = FIFO not full
//   data_bits           data field length, clamped to 5..MAX_DATAWIDTH
//   parity_mode         00/11 none, 01 even, 10 odd
//   stop2               two stop bits when set
//   s_tick              oversampling tick, SB_TICK per bit
//   tx                  serial line, idle high, registered
//   tx_done/tx_busy     end-of-frame pulse / frame in progress
//   fifo_count          entries currently queued
module uart_tx_cfg #(
   parameter int MAX_DATAWIDTH = 9,
   parameter int SB_TICK       = 16,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                          clk,
   input  logic                          tx_rst_n,
   input  logic                          tx_en,
   input  logic [MAX_DATAWIDTH-1:0]      din,
   input  logic                          din_valid,
   output logic                          din_ready,
   input  logic [3:0]                    data_bits,
   input  logic [1:0]                    parity_mode,
   input  logic                          stop2,
   input  logic                          s_tick,
   output logic                          tx,
   output logic                          tx_done,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(2 * SB_TICK);
   localparam logic [TW-1:0] T1   = TW'(SB_TICK - 1);
   localparam logic [TW-1:0] T2   = TW'(2 * SB_TICK - 1);
   localparam logic [3:0]    NMAX = 4'(MAX_DATAWIDTH);
   localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;

   // FIFO
   logic [MAX_DATAWIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]            wr_q, rd_q;
   logic [AW:0]              cnt_q;
   logic                     push, pop;
   logic [MAX_DATAWIDTH-1:0] head;

   assign din_ready  = (cnt_q != FULL);
   assign push       = din_valid && din_ready;
   assign fifo_count = cnt_q;
   assign head       = mem_q[rd_q];

   always_ff @(posedge clk) begin
      if (!tx_rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= din;
   end

   // Frame config of the head word, captured at pop
   logic [3:0] nb_clamp;
   logic       head_xor;

   always_comb begin
      if (data_bits < 4'd5)      nb_clamp = 4'd5;
      else if (data_bits > NMAX) nb_clamp = NMAX;
      else                       nb_clamp = data_bits;
   end

   // Parity covers only the bits actually sent
   always_comb begin
      head_xor = 1'b0;
      for (int i = 0; i < MAX_DATAWIDTH; i++) begin
         if (4'(i) < nb_clamp) head_xor = head_xor ^ head[i];
      end
   end

   // FSM
   state_t                   state_q, state_d;
   logic [TW-1:0]            tick_q, tick_d;
   logic [3:0]               bit_q, bit_d;
   logic [MAX_DATAWIDTH-1:0] sh_q, sh_d;
   logic [3:0]               nb_q, nb_d;
   logic                     pen_q, pen_d;
   logic                     pbit_q, pbit_d;
   logic                     s2_q, s2_d;
   logic                     tx_q, tx_d;
   logic                     done_q, done_d;
   logic                     busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      nb_d    = nb_q;
      pen_d   = pen_q;
      pbit_d  = pbit_q;
      s2_d    = s2_q;
      done_d  = 1'b0;
      pop     = 1'b0;
      if (tx_en) begin
         unique case (state_q)
            IDLE: begin
               if (cnt_q != '0) begin
                  pop     = 1'b1;
                  sh_d    = head;
                  tick_d  = '0;
                  bit_d   = '0;
                  nb_d    = nb_clamp;
                  pen_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                  pbit_d  = head_xor ^ (parity_mode == 2'b10);
                  s2_d    = stop2;
                  state_d = START;
               end
            end
            START: begin
               if (s_tick) begin
                  if (tick_q == T1) begin
                     tick_d  = '0;
                     state_d = DATA;
                  end else begin
                     tick_d = tick_q + 1'b1;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (tick_q == T1) begin
                     tick_d = '0;
                     if (bit_q == nb_q - 4'd1) begin
                        state_d = pen_q ? PARITY : STOP;
                     end else begin
                        bit_d = bit_q + 4'd1;
                        sh_d  = sh_q >> 1;
                     end
                  end else begin
                     tick_d = tick_q + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (s_tick) begin
                  if (tick_q == T1) begin
                     tick_d  = '0;
                     state_d = STOP;
                  end else begin
                     tick_d = tick_q + 1'b1;
                  end
               end
            end
            STOP: begin
               if (s_tick) begin
                  if (tick_q == (s2_q ? T2 : T1)) begin
                     tick_d  = '0;
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     tick_d = tick_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end

      // Line level follows the state being entered
      unique case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = sh_d[0];
         PARITY:  tx_d = pbit_d;
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!tx_rst_n) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         nb_q    <= 4'd5;
         pen_q   <= 1'b0;
         pbit_q  <= 1'b0;
         s2_q    <= 1'b0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         nb_q    <= nb_d;
         pen_q   <= pen_d;
         pbit_q  <= pbit_d;
         s2_q    <= s2_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign tx      = tx_q;
   assign tx_done = done_q;
   assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: stimulus queues expected frames,
// a line monitor decodes tx and checks each frame against the queue.
module tb_uart_tx_cfg;

   localparam int MAXW  = 9;
   localparam int SB    = 16;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            tx_rst_n;
   logic            tx_en;
   logic [MAXW-1:0] din;
   logic            din_valid;
   logic            din_ready;
   logic [3:0]      data_bits;
   logic [1:0]      parity_mode;
   logic            stop2;
   logic            s_tick;
   logic            tx;
   logic            tx_done;
   logic            tx_busy;
   logic [2:0]      fifo_count;

   always #5 clk = ~clk;

   uart_tx_cfg #(
      .MAX_DATAWIDTH(MAXW),
      .SB_TICK(SB),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .tx_rst_n(tx_rst_n),
      .tx_en(tx_en),
      .din(din),
      .din_valid(din_valid),
      .din_ready(din_ready),
      .data_bits(data_bits),
      .parity_mode(parity_mode),
      .stop2(stop2),
      .s_tick(s_tick),
      .tx(tx),
      .tx_done(tx_done),
      .tx_busy(tx_busy),
      .fifo_count(fifo_count)
   );

   typedef struct {
      logic [8:0] d;
      int         n;
      bit         p;
      bit         pb;
      bit         s2;
      int         len;
      int         gap;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   eff = 0;
   bit   rst_p = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   function automatic exp_t mk(input logic [8:0] d, input int n,
                               input bit p, input bit pb, input bit s2,
                               input int len, input int gap);
      exp_t e;
      e.d = d; e.n = n; e.p = p; e.pb = pb;
      e.s2 = s2; e.len = len; e.gap = gap;
      return e;
   endfunction

   // Effective ticks: the only ticks the transmitter is allowed to count
   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_p <= !tx_rst_n;
      if (tx_en && s_tick) eff <= eff + 1;
   end

   // Line monitor
   bit   mon_act = 1'b0;
   exp_t cur;
   int   k0, c0, js, tot;
   int   done_cyc = -1000;

   always @(negedge clk) begin
      bit   end_now;
      int   kk;
      logic eb;
      end_now = 1'b0;
      if (rst_p) begin
         mon_act = 1'b0;
      end else if (!mon_act) begin
         if (tx === 1'b0) begin
            chk("start_queued", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               cur     = exp_q.pop_front();
               mon_act = 1'b1;
               k0      = eff;
               c0      = cyc;
               js      = 0;
               tot     = 2 + cur.n + int'(cur.p) + int'(cur.s2);
               chk("busy_start", tx_busy, 1);
               if (cur.gap >= 0) chk("idle_gap", cyc - done_cyc, cur.gap);
            end
         end
      end else begin
         kk = eff - k0;
         if (js < tot && kk == SB * js + SB / 2) begin
            if (js == 0)                         eb = 1'b0;
            else if (js <= cur.n)                eb = cur.d[js-1];
            else if (cur.p && js == cur.n + 1)   eb = cur.pb;
            else                                 eb = 1'b1;
            chk($sformatf("bit%0d_d%0h", js, cur.d), tx, eb);
            chk("busy_mid", tx_busy, 1);
            js++;
         end
         if (kk == SB * tot) begin
            end_now = 1'b1;
            chk("done_pulse", tx_done, 1);
            chk($sformatf("frame_len_d%0h", cur.d), cyc - c0, cur.len);
            chk("busy_end", tx_busy, 0);
            chk("tx_idle_end", tx, 1);
            mon_act  = 1'b0;
            done_cyc = cyc;
         end
      end
      if (!end_now && cyc > 1) chk("no_stray_done", tx_done, 0);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [8:0] d, input exp_t e, input bit acc);
      din       = d;
      din_valid = 1'b1;
      chk("din_ready", din_ready, acc);
      if (acc) exp_q.push_back(e);
      step(1);
      din_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int i;
      for (i = 0; i < budget; i++) begin
         if (exp_q.size() == 0 && !mon_act) break;
         step(1);
      end
      chk(nm, i < budget, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int   chg;
      logic v;
      tx_rst_n    = 1'b0;
      tx_en       = 1'b1;
      din         = '0;
      din_valid   = 1'b0;
      data_bits   = 4'd8;
      parity_mode = 2'b00;
      stop2       = 1'b0;
      s_tick      = 1'b1;
      step(3);
      chk("rst_tx", tx, 1);
      chk("rst_done", tx_done, 0);
      chk("rst_busy", tx_busy, 0);
      chk("rst_ready", din_ready, 1);
      chk("rst_count", fifo_count, 0);
      tx_rst_n = 1'b1;
      step(2);

      // 8N1
      push(9'h0A5, mk(9'h0A5, 8, 0, 0, 0, 160, -1), 1);
      wait_idle(400, "t1_timeout");

      // 7E2 / 7O2, then 5E1 with upper bits that must not affect parity
      data_bits = 4'd7; parity_mode = 2'b01; stop2 = 1'b1;
      push(9'h003, mk(9'h003, 7, 1, 0, 1, 176, -1), 1);
      wait_idle(400, "t2e_timeout");
      parity_mode = 2'b10;
      push(9'h003, mk(9'h003, 7, 1, 1, 1, 176, -1), 1);
      wait_idle(400, "t2o_timeout");
      data_bits = 4'd5; parity_mode = 2'b01; stop2 = 1'b0;
      push(9'h1E1, mk(9'h1E1, 5, 1, 1, 0, 128, -1), 1);
      wait_idle(400, "t2p_timeout");

      // Fill FIFO while frozen, then drain back-to-back
      data_bits = 4'd8; parity_mode = 2'b00;
      tx_en = 1'b0;
      push(9'h011, mk(9'h011, 8, 0, 0, 0, 160, -1), 1);
      push(9'h022, mk(9'h022, 8, 0, 0, 0, 160, 1), 1);
      push(9'h033, mk(9'h033, 8, 0, 0, 0, 160, 1), 1);
      push(9'h044, mk(9'h044, 8, 0, 0, 0, 160, 1), 1);
      push(9'h055, mk(9'h055, 8, 0, 0, 0, 160, 1), 0);
      chk("full_count", fifo_count, 4);
      step(5);
      chk("frozen_tx", tx, 1);
      chk("frozen_busy", tx_busy, 0);
      tx_en = 1'b1;
      wait_idle(1000, "t3_timeout");
      chk("drained_count", fifo_count, 0);

      // Config latched at pop; clamping
      push(9'h0F0, mk(9'h0F0, 8, 0, 0, 0, 160, -1), 1);
      push(9'h1F3, mk(9'h1F3, 5, 0, 0, 0, 112, 1), 1);
      step(50);
      data_bits = 4'd5;
      wait_idle(600, "t4a_timeout");
      data_bits = 4'd2;
      push(9'h015, mk(9'h015, 5, 0, 0, 0, 112, -1), 1);
      wait_idle(400, "t4b_timeout");
      data_bits = 4'd15; parity_mode = 2'b11;
      push(9'h1A5, mk(9'h1A5, 9, 0, 0, 0, 176, -1), 1);
      wait_idle(400, "t4c_timeout");

      // tx_en drop inside data bit 3
      data_bits = 4'd8; parity_mode = 2'b00;
      push(9'h0C3, mk(9'h0C3, 8, 0, 0, 0, 180, -1), 1);
      step(72);
      v     = tx;
      chg   = 0;
      tx_en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (tx !== v || tx_busy !== 1'b1) chg++;
      end
      chk("hold_changes", chg, 0);
      chk("hold_level", v, 0);
      tx_en = 1'b1;
      wait_idle(400, "t5_timeout");

      // Reset mid-frame with two words queued
      push(9'h0AA, mk(9'h0AA, 8, 0, 0, 0, 160, -1), 1);
      push(9'h155, mk(9'h155, 8, 0, 0, 0, 160, 1), 1);
      push(9'h0FF, mk(9'h0FF, 8, 0, 0, 0, 160, 1), 1);
      chk("queued_count", fifo_count, 2);
      step(40);
      tx_rst_n = 1'b0;
      step(1);
      chk("mrst_tx", tx, 1);
      chk("mrst_busy", tx_busy, 0);
      chk("mrst_count", fifo_count, 0);
      chk("mrst_done", tx_done, 0);
      chk("mrst_ready", din_ready, 1);
      exp_q.delete();
      tx_rst_n = 1'b1;
      step(400);
      chk("post_rst_tx", tx, 1);
      chk("post_rst_busy", tx_busy, 0);
      chk("post_rst_count", fifo_count, 0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
